// File: rtl/fdau_pkg.sv
// ============================================================================
// fdau_pkg - shared state encoding, header tag and frame-length helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package fdau_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_ADC_WAIT = 3'd2,
        ST_ADC_REL  = 3'd3,
        ST_AUX      = 3'd4,
        ST_DIG_ADDR = 3'd5,
        ST_DIG_WR   = 3'd6,
        ST_DONE     = 3'd7
    } fdau_state_t;

    localparam logic [3:0] c_HDR_TAG = 4'hA;

    function automatic int unsigned frame_len(input int unsigned n_adc, input int unsigned n_aux,
                                              input int unsigned n_dig, input int unsigned dig_depth);
        return 1 + n_adc + n_aux + n_dig * dig_depth;
    endfunction

    function automatic bit frame_fits(input int unsigned len, input int unsigned aw);
        return len <= (32'd1 << (aw - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fdau_bank_ctrl.sv
// ============================================================================
// fdau_bank_ctrl - ping-pong bank ownership, release and overrun tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module fdau_bank_ctrl (
    input  logic clock,
    input  logic reset_n,
    input  logic i_done,
    input  logic i_rd_done,
    input  logic i_rd_bank,
    output logic o_wr_bank,
    output logic o_overrun
);

    logic [1:0] r_busy;
    logic       r_wr_bank;
    logic       r_overrun;
    logic [1:0] w_busy_next;
    logic       w_other_free;

    // A release in the same clock as frame completion is visible to the flip decision.
    always_comb begin
        w_busy_next = r_busy;
        if (i_rd_done) begin
            w_busy_next[i_rd_bank] = 1'b0;
        end
        w_other_free = ~w_busy_next[~r_wr_bank];
        if (i_done) begin
            w_busy_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (i_done) begin
                if (w_other_free) begin
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_wr_bank = r_wr_bank;
    assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/fdau_frame_builder.sv
// ============================================================================
// fdau_frame_builder - assembles header/ADC/aux/digital frames into a ping-pong RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module fdau_frame_builder
    import fdau_pkg::*;
#(
    parameter int unsigned N_ADC     = 64,
    parameter int unsigned N_AUX     = 3,
    parameter int unsigned N_DIG     = 6,
    parameter int unsigned DIG_DEPTH = 32,
    parameter int unsigned AW        = 10,
    parameter logic [3:0]  HDR_TAG   = c_HDR_TAG,
    localparam int unsigned DAW      = $clog2(DIG_DEPTH),
    localparam int unsigned AUX_W    = (N_AUX > 0) ? 16 * N_AUX : 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sec,
    input  logic             sample_rdy,
    input  logic [15:0]      adc_sample,
    input  logic [AUX_W-1:0] aux_data,
    output logic [3:0]       dig_ch,
    output logic [DAW-1:0]   dig_rdaddr,
    input  logic [15:0]      dig_data,
    output logic             ram_wren,
    output logic [AW-1:0]    ram_wraddr,
    output logic [15:0]      ram_data,
    input  logic             rd_done,
    input  logic             rd_bank,
    output logic             frame_rdy,
    output logic             frame_bank,
    output logic [11:0]      frame_seq,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned OW        = AW - 1;
    localparam int unsigned FRAME_LEN = frame_len(N_ADC, N_AUX, N_DIG, DIG_DEPTH);
    localparam int unsigned N_AUX_EFF = AUX_W / 16;
    localparam logic [7:0]     c_ADC_CNT   = 8'(N_ADC);
    localparam logic [3:0]     c_AUX_LAST  = 4'((N_AUX > 0) ? N_AUX - 1 : 0);
    localparam logic [3:0]     c_CH_LAST   = 4'(N_DIG - 1);
    localparam logic [DAW-1:0] c_ADDR_LAST = DAW'(DIG_DEPTH - 1);
    localparam fdau_state_t    c_AFTER_ADC = (N_AUX > 0) ? ST_AUX : ST_DIG_ADDR;

    if (!frame_fits(FRAME_LEN, AW)) begin : g_len_check
        $error("fdau_frame_builder: FRAME_LEN does not fit in one RAM bank");
    end

    fdau_state_t   r_state;
    logic [OW-1:0] r_off;
    logic [7:0]    r_adc_cnt;
    logic [3:0]    r_aux_idx;
    logic [11:0]   r_seq;
    logic          w_wr_bank;
    logic          w_done;
    logic [15:0]   w_aux_word;

    // An abort in DONE must not commit the frame to the bank controller.
    assign w_done = (r_state == ST_DONE) && !sec;

    always_comb begin
        w_aux_word = 16'h0000;
        for (int k = 0; k < N_AUX_EFF; k++) begin
            if (r_aux_idx == k[3:0]) begin
                w_aux_word = aux_data[16*k +: 16];
            end
        end
    end

    fdau_bank_ctrl u_bank_ctrl (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_done    (w_done),
        .i_rd_done (rd_done),
        .i_rd_bank (rd_bank),
        .o_wr_bank (w_wr_bank),
        .o_overrun (overrun)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_off      <= '0;
            r_adc_cnt  <= 8'd0;
            r_aux_idx  <= 4'd0;
            r_seq      <= 12'd0;
            dig_ch     <= 4'd0;
            dig_rdaddr <= '0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= 16'h0000;
            frame_rdy  <= 1'b0;
            frame_bank <= 1'b0;
            frame_seq  <= 12'd0;
            frame_err  <= 1'b0;
        end else begin
            ram_wren  <= 1'b0;
            frame_rdy <= 1'b0;
            frame_err <= 1'b0;
            if (sec && (r_state != ST_IDLE)) begin
                frame_err <= 1'b1;
                r_state   <= ST_HEADER;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (sec) begin
                            r_state <= ST_HEADER;
                        end
                    end
                    ST_HEADER: begin
                        ram_wren   <= 1'b1;
                        ram_wraddr <= {w_wr_bank, {OW{1'b0}}};
                        ram_data   <= {HDR_TAG, r_seq};
                        r_off      <= OW'(1);
                        r_adc_cnt  <= 8'd0;
                        r_aux_idx  <= 4'd0;
                        dig_ch     <= 4'd0;
                        dig_rdaddr <= '0;
                        r_state    <= ST_ADC_WAIT;
                    end
                    ST_ADC_WAIT: begin
                        if (sample_rdy) begin
                            ram_wren   <= 1'b1;
                            ram_wraddr <= {w_wr_bank, r_off};
                            ram_data   <= adc_sample;
                            r_off      <= r_off + 1'b1;
                            r_adc_cnt  <= r_adc_cnt + 8'd1;
                            r_state    <= ST_ADC_REL;
                        end
                    end
                    ST_ADC_REL: begin
                        if (!sample_rdy) begin
                            r_state <= (r_adc_cnt == c_ADC_CNT) ? c_AFTER_ADC : ST_ADC_WAIT;
                        end
                    end
                    ST_AUX: begin
                        ram_wren   <= 1'b1;
                        ram_wraddr <= {w_wr_bank, r_off};
                        ram_data   <= w_aux_word;
                        r_off      <= r_off + 1'b1;
                        r_aux_idx  <= r_aux_idx + 4'd1;
                        if (r_aux_idx == c_AUX_LAST) begin
                            r_state <= ST_DIG_ADDR;
                        end
                    end
                    ST_DIG_ADDR: begin
                        r_state <= ST_DIG_WR;
                    end
                    ST_DIG_WR: begin
                        ram_wren   <= 1'b1;
                        ram_wraddr <= {w_wr_bank, r_off};
                        ram_data   <= dig_data;
                        r_off      <= r_off + 1'b1;
                        if (dig_rdaddr == c_ADDR_LAST) begin
                            dig_rdaddr <= '0;
                            if (dig_ch == c_CH_LAST) begin
                                r_state <= ST_DONE;
                            end else begin
                                dig_ch  <= dig_ch + 4'd1;
                                r_state <= ST_DIG_ADDR;
                            end
                        end else begin
                            dig_rdaddr <= dig_rdaddr + 1'b1;
                            r_state    <= ST_DIG_ADDR;
                        end
                    end
                    ST_DONE: begin
                        frame_rdy  <= 1'b1;
                        frame_bank <= w_wr_bank;
                        frame_seq  <= r_seq;
                        r_seq      <= r_seq + 12'd1;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fdau_frame_builder.sv
// ============================================================================
// tb_fdau_frame_builder - directed self-checking bench for fdau_frame_builder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fdau_frame_builder;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        sec        = 1'b0;
    logic        sample_rdy = 1'b0;
    logic        rd_done    = 1'b0;
    logic        rd_bank    = 1'b0;
    logic [15:0] adc_sample = 16'h0000;
    logic [47:0] aux_data   = {16'h0333, 16'h0222, 16'h0111};
    logic [15:0] dig_data   = 16'h0000;
    logic [3:0]  dig_ch;
    logic [4:0]  dig_rdaddr;
    logic        ram_wren;
    logic [9:0]  ram_wraddr;
    logic [15:0] ram_data;
    logic        frame_rdy, frame_bank, overrun, frame_err;
    logic [11:0] frame_seq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:1023];
    int          n_wr = 0, n_wr1 = 0, n_hdr = 0, n_rdy = 0, n_err = 0;
    logic [9:0]  last_hdr_addr = 10'h3FF;
    logic [15:0] last_hdr_data = 16'hFFFF;

    fdau_frame_builder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sec        (sec),
        .sample_rdy (sample_rdy),
        .adc_sample (adc_sample),
        .aux_data   (aux_data),
        .dig_ch     (dig_ch),
        .dig_rdaddr (dig_rdaddr),
        .dig_data   (dig_data),
        .ram_wren   (ram_wren),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .rd_done    (rd_done),
        .rd_bank    (rd_bank),
        .frame_rdy  (frame_rdy),
        .frame_bank (frame_bank),
        .frame_seq  (frame_seq),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    // Digital buffer: synchronous read, word = {ch, addr}
    always @(posedge clock) begin
        dig_data <= {4'h0, dig_ch, 3'b000, dig_rdaddr};
    end

    always @(negedge clock) begin
        if (ram_wren) begin
            mem[ram_wraddr] <= ram_data;
            n_wr <= n_wr + 1;
            if (ram_wraddr[8:0] == 9'd1) n_wr1 <= n_wr1 + 1;
            if (ram_wraddr[8:0] == 9'd0) begin
                n_hdr         <= n_hdr + 1;
                last_hdr_addr <= ram_wraddr;
                last_hdr_data <= ram_data;
            end
        end
        if (frame_rdy) n_rdy <= n_rdy + 1;
        if (frame_err) n_err <= n_err + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clock);
        sec = 1'b1;
        @(negedge clock);
        sec = 1'b0;
    endtask

    task automatic send_samples(input int abort_at, input bit hold_first);
        int  i       = 0;
        bit  aborted = 1'b0;
        int  hi;
        while (i < 64) begin
            sample_rdy = 1'b0;
            repeat (2) @(negedge clock);
            adc_sample = 16'h1000 + 16'(i);
            sample_rdy = 1'b1;
            if (i == abort_at && !aborted) begin
                sec = 1'b1;
                @(negedge clock);
                sec     = 1'b0;
                aborted = 1'b1;
                i       = 0;
            end else begin
                hi = (hold_first && i == 0) ? 20 : 2;
                repeat (hi) @(negedge clock);
                i++;
            end
        end
        sample_rdy = 1'b0;
    endtask

    task automatic finish_frame(input bit do_rd, input bit rd_b);
        bit seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            if (ram_wren && ram_wraddr[8:0] == 9'd259) seen = 1'b1;
        end
        chk_eq("last_dig_write_seen", {31'd0, seen}, 32'd1);
        if (do_rd) begin
            rd_bank = rd_b;
            rd_done = 1'b1;
        end
        @(negedge clock);
        rd_done = 1'b0;
        chk_eq("frame_rdy_pulse", {31'd0, frame_rdy}, 32'd1);
        @(negedge clock);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_eq({tag, "_ram"}, {5'd0, ram_wren, ram_wraddr, ram_data}, 32'd0);
        chk_eq({tag, "_status"}, {7'd0, frame_rdy, frame_bank, frame_seq, overrun, frame_err,
                                  dig_ch, dig_rdaddr}, 32'd0);
    endtask

    initial begin
        int  w0, w10, r0, e0, h0;
        bit  seen;

        repeat (3) @(negedge clock);
        chk_outputs_zero("reset");
        reset_n = 1'b1;

        // Frame A: first sample held high for 20 clocks
        w0 = n_wr; w10 = n_wr1; r0 = n_rdy;
        start_frame();
        send_samples(-1, 1'b1);
        finish_frame(1'b0, 1'b0);
        chk_eq("A_hdr",       {16'd0, mem[0]},   32'h0000_A000);
        chk_eq("A_adc_first", {16'd0, mem[1]},   32'h0000_1000);
        chk_eq("A_adc_last",  {16'd0, mem[64]},  32'h0000_103F);
        chk_eq("A_aux0",      {16'd0, mem[65]},  32'h0000_0111);
        chk_eq("A_aux1",      {16'd0, mem[66]},  32'h0000_0222);
        chk_eq("A_aux2",      {16'd0, mem[67]},  32'h0000_0333);
        chk_eq("A_dig_first", {16'd0, mem[68]},  32'h0000_0000);
        chk_eq("A_dig_ch0_a5",{16'd0, mem[73]},  32'h0000_0005);
        chk_eq("A_dig_ch1_a0",{16'd0, mem[100]}, 32'h0000_0100);
        chk_eq("A_dig_last",  {16'd0, mem[259]}, 32'h0000_051F);
        chk_eq("A_held_sample_writes", n_wr1 - w10, 1);
        chk_eq("A_total_writes", n_wr - w0, 260);
        chk_eq("A_rdy_count", n_rdy - r0, 1);
        chk_eq("A_bank", {31'd0, frame_bank}, 0);
        chk_eq("A_seq", {20'd0, frame_seq}, 0);
        chk_eq("A_overrun", {31'd0, overrun}, 0);

        // Frame B: bank 0 still busy, so bank 1 is written and cannot be flipped away from
        start_frame();
        send_samples(-1, 1'b0);
        finish_frame(1'b0, 1'b0);
        chk_eq("B_bank", {31'd0, frame_bank}, 1);
        chk_eq("B_seq", {20'd0, frame_seq}, 1);
        chk_eq("B_overrun", {31'd0, overrun}, 1);
        chk_eq("B_hdr", {16'd0, mem[512]}, 32'h0000_A001);

        // Frame C: overwrites bank 1
        start_frame();
        send_samples(-1, 1'b0);
        finish_frame(1'b0, 1'b0);
        chk_eq("C_bank", {31'd0, frame_bank}, 1);
        chk_eq("C_seq", {20'd0, frame_seq}, 2);
        chk_eq("C_overrun", {31'd0, overrun}, 1);

        // Reset asserted during DIG_WR of a partial frame
        start_frame();
        send_samples(-1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clock);
            if (ram_wren && ram_wraddr[8:0] == 9'd100) seen = 1'b1;
        end
        chk_eq("rst_mid_dig_seen", {31'd0, seen}, 1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        r0 = n_rdy; w0 = n_wr;
        repeat (700) @(negedge clock);
        #1;
        chk_eq("rst_no_rdy", n_rdy - r0, 0);
        chk_eq("rst_no_writes", n_wr - w0, 0);

        // Frame E: clean start in bank 0 with seq 0
        start_frame();
        send_samples(-1, 1'b0);
        finish_frame(1'b0, 1'b0);
        chk_eq("E_hdr", {6'd0, last_hdr_addr, last_hdr_data}, {6'd0, 10'd0, 16'hA000});
        chk_eq("E_bank", {31'd0, frame_bank}, 0);
        chk_eq("E_seq", {20'd0, frame_seq}, 0);
        chk_eq("E_overrun", {31'd0, overrun}, 0);

        // Frame F: bank 0 released in the DONE clock
        start_frame();
        send_samples(-1, 1'b0);
        finish_frame(1'b1, 1'b0);
        chk_eq("F_bank", {31'd0, frame_bank}, 1);
        chk_eq("F_seq", {20'd0, frame_seq}, 1);
        chk_eq("F_overrun", {31'd0, overrun}, 0);

        // Frame G: lands in bank 0, bank 1 released in its DONE clock
        start_frame();
        send_samples(-1, 1'b0);
        finish_frame(1'b1, 1'b1);
        chk_eq("G_bank", {31'd0, frame_bank}, 0);
        chk_eq("G_seq", {20'd0, frame_seq}, 2);
        chk_eq("G_overrun", {31'd0, overrun}, 0);

        // Frame H: sec during ADC sample 10
        e0 = n_err; h0 = n_hdr; r0 = n_rdy;
        start_frame();
        send_samples(10, 1'b0);
        finish_frame(1'b0, 1'b0);
        chk_eq("H_err_count", n_err - e0, 1);
        chk_eq("H_hdr_writes", n_hdr - h0, 2);
        chk_eq("H_rdy_count", n_rdy - r0, 1);
        chk_eq("H_hdr", {16'd0, mem[512]}, 32'h0000_A003);
        chk_eq("H_bank", {31'd0, frame_bank}, 1);
        chk_eq("H_seq", {20'd0, frame_seq}, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
